// File: rtl/tdc_echo_packer.sv
`default_nettype none
// ============================================================================
// Module   : tdc_echo_packer
// Purpose  : Groups TDC echo strobes into laser shots, computes pulse width and
//            streams one 64-bit point record per echo (or per empty shot)
//            through a first-word-fall-through record FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module tdc_echo_packer #(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned MAX_ECHO   = 3,
  parameter logic [15:0] WIN_CLKS   = 16'd2000,
  parameter logic [15:0] MIN_WIDTH  = 16'd0
) (
  input  logic                          i_clk_100m,
  input  logic                          i_rst,
  input  logic                          i_tdc_strdy,
  input  logic                          i_tdc_sig,
  input  logic [15:0]                   i_tdc_rdata,
  input  logic [15:0]                   i_tdc_fdata,
  input  logic [15:0]                   i_tdc_angle1,
  input  logic [3:0]                    i_tdc_lasernum,
  output logic                          o_pkt_valid,
  input  logic                          i_pkt_ready,
  output logic [63:0]                   o_pkt_data,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level,
  output logic [15:0]                   o_ovf_cnt,
  output logic [15:0]                   o_stray_cnt
);

  localparam int unsigned          c_ptr_w    = $clog2(FIFO_DEPTH);
  localparam logic [2:0]           c_max_echo = 3'(MAX_ECHO);
  localparam logic [15:0]          c_win_last = WIN_CLKS - 16'd1;
  localparam logic [c_ptr_w:0]     c_lvl_full = (c_ptr_w + 1)'(FIFO_DEPTH);
  localparam logic [c_ptr_w:0]     c_lvl_one  = (c_ptr_w + 1)'(1);
  localparam logic [c_ptr_w-1:0]   c_ptr_one  = c_ptr_w'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LATCH = 2'd1,
    ST_ARMED = 2'd2,
    ST_CLOSE = 2'd3
  } state_t;

  state_t              r_state;
  logic                r_strdy_pend;
  logic [15:0]         r_win_cnt;
  logic [2:0]          r_echo_cnt;
  logic [15:0]         r_angle;
  logic [3:0]          r_laser;
  logic                r_stage_vld;
  logic [63:0]         r_stage_rec;
  logic [15:0]         r_stray_cnt;
  logic [15:0]         r_ovf_cnt;

  logic [63:0]         r_mem [FIFO_DEPTH];
  logic [c_ptr_w-1:0]  r_wr_ptr;
  logic [c_ptr_w-1:0]  r_rd_ptr;
  logic [c_ptr_w:0]    r_level;

  logic                w_werr;
  logic [15:0]         w_width;
  logic                w_pass;
  logic                w_keep;
  logic                w_stray;
  logic [63:0]         w_echo_rec;
  logic [63:0]         w_noecho_rec;
  logic                w_full;
  logic                w_empty;
  logic                w_push_ok;
  logic                w_pop;

  // Reversed edges are kept as werr records and bypass the width filter.
  assign w_werr       = (i_tdc_fdata < i_tdc_rdata);
  assign w_width      = w_werr ? 16'h0000 : (i_tdc_fdata - i_tdc_rdata);
  assign w_pass       = w_werr || (w_width >= MIN_WIDTH);
  assign w_keep       = (r_state == ST_ARMED) && i_tdc_sig && w_pass && (r_echo_cnt < c_max_echo);
  assign w_stray      = i_tdc_sig && (r_state != ST_ARMED);

  assign w_echo_rec   = {r_laser, r_echo_cnt[1:0], 1'b0, w_werr, r_angle,
                         i_tdc_rdata, w_width, 8'h00};
  assign w_noecho_rec = {r_laser, 2'b00, 1'b1, 1'b0, r_angle, 16'h0000, 16'h0000, 8'h00};

  always_ff @(posedge i_clk_100m or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_strdy_pend <= 1'b0;
      r_win_cnt    <= 16'h0000;
      r_echo_cnt   <= 3'd0;
      r_angle      <= 16'h0000;
      r_laser      <= 4'h0;
      r_stage_vld  <= 1'b0;
      r_stage_rec  <= 64'h0;
    end else begin
      r_stage_vld <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_tdc_strdy) begin
            r_state <= ST_LATCH;
          end
        end
        ST_LATCH: begin
          r_angle      <= i_tdc_angle1;
          r_laser      <= i_tdc_lasernum;
          r_echo_cnt   <= 3'd0;
          r_win_cnt    <= 16'h0000;
          r_strdy_pend <= 1'b0;
          r_state      <= ST_ARMED;
        end
        ST_ARMED: begin
          r_win_cnt <= r_win_cnt + 16'd1;
          if (w_keep) begin
            r_stage_vld <= 1'b1;
            r_stage_rec <= w_echo_rec;
            r_echo_cnt  <= r_echo_cnt + 3'd1;
          end
          if (i_tdc_strdy) begin
            r_strdy_pend <= 1'b1;
          end
          if (i_tdc_strdy || (r_win_cnt == c_win_last)) begin
            r_state <= ST_CLOSE;
          end
        end
        ST_CLOSE: begin
          if (r_echo_cnt == 3'd0) begin
            r_stage_vld <= 1'b1;
            r_stage_rec <= w_noecho_rec;
          end
          r_strdy_pend <= 1'b0;
          r_state      <= (r_strdy_pend || i_tdc_strdy) ? ST_LATCH : ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk_100m or posedge i_rst) begin
    if (i_rst) begin
      r_stray_cnt <= 16'h0000;
    end else if (w_stray && (r_stray_cnt != 16'hFFFF)) begin
      r_stray_cnt <= r_stray_cnt + 16'd1;
    end
  end

  // Fullness is judged on the stored level, so a concurrent pop never makes room.
  assign w_full    = (r_level == c_lvl_full);
  assign w_empty   = (r_level == '0);
  assign w_push_ok = r_stage_vld && !w_full;
  assign w_pop     = !w_empty && i_pkt_ready;

  always_ff @(posedge i_clk_100m) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= r_stage_rec;
    end
  end

  always_ff @(posedge i_clk_100m or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_level   <= '0;
      r_ovf_cnt <= 16'h0000;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_one;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_one;
      end
      case ({w_push_ok, w_pop})
        2'b10:   r_level <= r_level + c_lvl_one;
        2'b01:   r_level <= r_level - c_lvl_one;
        default: r_level <= r_level;
      endcase
      if (r_stage_vld && w_full && (r_ovf_cnt != 16'hFFFF)) begin
        r_ovf_cnt <= r_ovf_cnt + 16'd1;
      end
    end
  end

  assign o_pkt_valid  = !w_empty;
  assign o_pkt_data   = w_empty ? 64'h0 : r_mem[r_rd_ptr];
  assign o_fifo_level = r_level;
  assign o_ovf_cnt    = r_ovf_cnt;
  assign o_stray_cnt  = r_stray_cnt;

endmodule
`default_nettype wire

// File: tb/tb_tdc_echo_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_tdc_echo_packer
// Purpose  : Directed shot sequences with randomized echo data, checked
//            against a shot-level record model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tdc_echo_packer;

  localparam int          P_DEPTH = 16;
  localparam int          P_MAX   = 3;
  localparam int          P_WIN   = 64;
  localparam logic [15:0] P_MIN   = 16'd4;

  logic        clk = 1'b0;
  logic        rst;
  logic        tdc_strdy, tdc_sig, pkt_ready, pkt_valid;
  logic [15:0] tdc_rdata, tdc_fdata, tdc_angle1;
  logic [3:0]  tdc_lasernum;
  logic [63:0] pkt_data;
  logic [4:0]  fifo_level;
  logic [15:0] ovf_cnt, stray_cnt;

  always #5 clk = ~clk;

  tdc_echo_packer #(
    .FIFO_DEPTH (P_DEPTH),
    .MAX_ECHO   (P_MAX),
    .WIN_CLKS   (16'(P_WIN)),
    .MIN_WIDTH  (P_MIN)
  ) dut (
    .i_clk_100m     (clk),
    .i_rst          (rst),
    .i_tdc_strdy    (tdc_strdy),
    .i_tdc_sig      (tdc_sig),
    .i_tdc_rdata    (tdc_rdata),
    .i_tdc_fdata    (tdc_fdata),
    .i_tdc_angle1   (tdc_angle1),
    .i_tdc_lasernum (tdc_lasernum),
    .o_pkt_valid    (pkt_valid),
    .i_pkt_ready    (pkt_ready),
    .o_pkt_data     (pkt_data),
    .o_fifo_level   (fifo_level),
    .o_ovf_cnt      (ovf_cnt),
    .o_stray_cnt    (stray_cnt)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [63:0] exp_q[$];
  int          m_ovf, m_stray, m_kept, armed_j;
  logic [15:0] m_angle;
  logic [3:0]  m_laser;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [63:0] mk_rec(input logic [3:0] laser, input int idx, input logic noecho,
                                         input logic werr, input logic [15:0] angle,
                                         input logic [15:0] rise, input logic [15:0] width);
    logic [1:0] i2;
    i2 = 2'(idx);
    return {laser, i2, noecho, werr, angle, rise, width, 8'h00};
  endfunction

  // A record either lands in the FIFO or, once 16 are held, counts as lost.
  task automatic model_push(input logic [63:0] rec);
    if (exp_q.size() < P_DEPTH) exp_q.push_back(rec);
    else if (m_ovf < 65535) m_ovf++;
  endtask

  task automatic model_echo(input logic [15:0] r, input logic [15:0] f);
    int   w;
    logic werr;
    if (int'(f) >= int'(r)) begin
      w    = int'(f) - int'(r);
      werr = 1'b0;
      if (w < int'(P_MIN)) return;
    end else begin
      w    = 0;
      werr = 1'b1;
    end
    if (m_kept < P_MAX) begin
      model_push(mk_rec(m_laser, m_kept, 1'b0, werr, m_angle, r, 16'(w)));
      m_kept++;
    end
  endtask

  task automatic model_close();
    if (m_kept == 0) model_push(mk_rec(m_laser, 0, 1'b1, 1'b0, m_angle, 16'h0, 16'h0));
  endtask

  task automatic scramble();
    tdc_angle1   = 16'($urandom);
    tdc_lasernum = 4'($urandom);
  endtask

  // Leaves the bench at the first ARMED cycle of a new shot.
  task automatic start_shot(input logic [15:0] ang, input logic [3:0] ls);
    tdc_strdy = 1'b1; tdc_angle1 = ang; tdc_lasernum = ls;
    tick();
    tdc_strdy = 1'b0;
    m_angle = ang; m_laser = ls; m_kept = 0;
    tick();
    scramble();
    armed_j = 0;
  endtask

  task automatic arm_cycle(input logic sig, input logic [15:0] r, input logic [15:0] f);
    tdc_sig = sig; tdc_rdata = r; tdc_fdata = f;
    if (sig) model_echo(r, f);
    tick();
    tdc_sig = 1'b0;
    armed_j++;
  endtask

  task automatic end_window();
    while (armed_j < P_WIN) arm_cycle(1'b0, 16'h0, 16'h0);
    model_close();
    tick();
  endtask

  task automatic rand_echo(output logic [15:0] r, output logic [15:0] f);
    r = 16'($urandom_range(0, 30000));
    f = r + 16'($urandom_range(int'(P_MIN), 2000));
  endtask

  task automatic drain(input string tag);
    int n, waitc;
    n = exp_q.size();
    pkt_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      waitc = 0;
      while (!pkt_valid && waitc < 8) begin tick(); waitc++; end
      if (!pkt_valid) begin
        check({tag, "_timeout"}, 64'(pkt_valid), 64'd1);
        break;
      end
      check(tag, pkt_data, exp_q.pop_front());
      tick();
    end
    pkt_ready = 1'b0;
    exp_q.delete();
    check({tag, "_level0"}, 64'(fifo_level), 64'd0);
    check({tag, "_valid0"}, 64'(pkt_valid), 64'd0);
  endtask

  task automatic check_counters(input string tag);
    check({tag, "_ovf"}, 64'(ovf_cnt), 64'(m_ovf));
    check({tag, "_stray"}, 64'(stray_cnt), 64'(m_stray));
  endtask

  initial begin
    logic [15:0] r, f, ang_b;
    logic [3:0]  las_b;
    rst = 1'b1; tdc_strdy = 1'b0; tdc_sig = 1'b0; pkt_ready = 1'b0;
    tdc_rdata = '0; tdc_fdata = '0; tdc_angle1 = '0; tdc_lasernum = '0;
    m_ovf = 0; m_stray = 0; m_kept = 0; armed_j = 0; m_angle = '0; m_laser = '0;
    repeat (3) tick();
    check("rst_valid", 64'(pkt_valid), 64'd0);
    check("rst_data", pkt_data, 64'd0);
    check("rst_level", 64'(fifo_level), 64'd0);
    check_counters("rst");
    rst = 1'b0;
    tick();

    // Single echo: exact record and two-cycle latency
    start_shot(16'h1234, 4'd5);
    while (armed_j < 8) arm_cycle(1'b0, 16'h0, 16'h0);
    arm_cycle(1'b1, 16'd100, 16'd160);
    check("t1_lat_n1", 64'(pkt_valid), 64'd0);
    arm_cycle(1'b0, 16'h0, 16'h0);
    check("t1_lat_n2", 64'(pkt_valid), 64'd1);
    check("t1_rec", pkt_data, {4'd5, 2'd0, 1'b0, 1'b0, 16'h1234, 16'd100, 16'd60, 8'h00});
    end_window();
    drain("t1_drain");
    check_counters("t1");

    // Empty shot yields one no-echo record
    start_shot(16'hBEEF, 4'd9);
    while (armed_j < P_WIN) arm_cycle(1'b0, 16'h0, 16'h0);
    check("t2_close_valid", 64'(pkt_valid), 64'd0);
    model_close();
    tick();
    check("t2_close1_valid", 64'(pkt_valid), 64'd0);
    tick();
    check("t2_close2_valid", 64'(pkt_valid), 64'd1);
    check("t2_level", 64'(fifo_level), 64'd1);
    check("t2_rec", pkt_data, {4'd9, 2'd0, 1'b1, 1'b0, 16'hBEEF, 16'd0, 16'd0, 8'h00});
    drain("t2_drain");

    // Narrow echo filtered, reversed echo kept as werr, echoes past MAX_ECHO dropped
    start_shot(16'($urandom), 4'($urandom));
    arm_cycle(1'b1, 16'd1000, 16'd1002);
    arm_cycle(1'b0, 16'h0, 16'h0);
    rand_echo(r, f); arm_cycle(1'b1, r, f);
    arm_cycle(1'b1, 16'd500, 16'd200);
    rand_echo(r, f); arm_cycle(1'b1, r, f);
    rand_echo(r, f); arm_cycle(1'b1, r, f);
    arm_cycle(1'b0, 16'h0, 16'h0);
    rand_echo(r, f); arm_cycle(1'b1, r, f);
    end_window();
    check("t3_level", 64'(fifo_level), 64'd3);
    drain("t3_drain");
    check_counters("t3");

    // Strobe while idle is stray
    tdc_sig = 1'b1; tick(); tdc_sig = 1'b0; m_stray++;
    tick();
    check_counters("t3b");

    // Overflow: 20 records into a 16-deep FIFO with consumer stalled
    for (int s = 0; s < 7; s++) begin
      start_shot(16'($urandom), 4'($urandom));
      for (int e = 0; e < ((s == 6) ? 2 : 3); e++) begin
        rand_echo(r, f);
        arm_cycle(1'b1, r, f);
        arm_cycle(1'b0, 16'h0, 16'h0);
      end
      end_window();
    end
    repeat (2) tick();
    check("t4_level", 64'(fifo_level), 64'd16);
    check("t4_ovf_abs", 64'(ovf_cnt), 64'd4);
    check_counters("t4");
    drain("t4_drain");

    // New strdy with simultaneous echo; echo during LATCH is stray
    start_shot(16'($urandom), 4'($urandom));
    rand_echo(r, f); arm_cycle(1'b1, r, f);
    repeat (5) arm_cycle(1'b0, 16'h0, 16'h0);
    ang_b = 16'($urandom); las_b = 4'($urandom);
    rand_echo(r, f);
    tdc_strdy = 1'b1; tdc_sig = 1'b1; tdc_rdata = r; tdc_fdata = f;
    tdc_angle1 = ang_b; tdc_lasernum = las_b;
    model_echo(r, f);
    tick();
    tdc_strdy = 1'b0; tdc_sig = 1'b0;
    model_close();
    m_angle = ang_b; m_laser = las_b; m_kept = 0;
    tick();
    rand_echo(r, f);
    tdc_sig = 1'b1; tdc_rdata = r; tdc_fdata = f; m_stray++;
    tick();
    tdc_sig = 1'b0; scramble(); armed_j = 0;
    check_counters("t5_latch");
    rand_echo(r, f); arm_cycle(1'b1, r, f);
    end_window();
    drain("t5_drain");
    check_counters("t5");

    // Asynchronous reset while armed with records queued
    start_shot(16'($urandom), 4'($urandom));
    rand_echo(r, f); arm_cycle(1'b1, r, f);
    rand_echo(r, f); arm_cycle(1'b1, r, f);
    repeat (2) arm_cycle(1'b0, 16'h0, 16'h0);
    check("t6_level_pre", 64'(fifo_level), 64'd2);
    #2 rst = 1'b1;
    #1;
    exp_q.delete(); m_ovf = 0; m_stray = 0;
    check("t6_valid", 64'(pkt_valid), 64'd0);
    check("t6_data", pkt_data, 64'd0);
    check("t6_level", 64'(fifo_level), 64'd0);
    check_counters("t6");
    tick();
    rst = 1'b0;
    repeat (P_WIN + 10) tick();
    check("t6_post_valid", 64'(pkt_valid), 64'd0);
    check("t6_post_level", 64'(fifo_level), 64'd0);
    check_counters("t6_post");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
